// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and direction encodings
package gray_pkg;

    // Widest vector the helper functions operate on; narrower callers zero-extend.
    localparam int GRAY_MAX_W = 32;

    // Direction encodings for the Up input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Binary to reflected-binary Gray.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected-binary Gray back to binary: each binary bit is the XOR of all
    // Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_enc.sv
// rtl/gray_enc.sv - combinational binary to Gray encoder
module gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Adjacent binary values differ in exactly one bit after this mapping.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - up/down Gray counter with load and sticky wrap flags (GRAY_COUNTER_SATURATE_EN selects saturation)
module gray_counter_n #(
    parameter int WIDTH = 4,
    parameter int INIT  = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Terminal
);

    import gray_pkg::*;

    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == CNT_MAX);
    assign at_zero = (cnt_q == CNT_ZERO);

    // Gray code of the next count, so Output is a flop aligned with BinOut.
    gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    // Next count and flag state: load beats count, flag clear loses to a same-cycle wrap.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = FlagClr ? 1'b0 : ovf_q;
        unf_d = FlagClr ? 1'b0 : unf_q;
        if (Load) begin
            cnt_d = LoadVal;
        end else if (En) begin
            if (Up == DIR_UP) begin
                if (at_max) begin
                    ovf_d = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = CNT_ZERO;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (at_zero) begin
                    unf_d = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = CNT_MAX;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
    end

    // State registers with asynchronous return to the INIT value.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Terminal looks at direction and count only; En does not gate it.
    always_comb begin
        Terminal = ((Up == DIR_UP) && at_max) || ((Up == DIR_DOWN) && at_zero);
    end

    assign Output    = gray_q;
    assign BinOut    = cnt_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule
